// File: rtl/ft2232h_tx_stream_if.sv
// Bundle of stream-side and FT2232H-side signals for the transmit streamer.
// master = stream source / device model, slave = ft2232h_tx_stream.
interface ft2232h_tx_stream_if #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 32
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic             enable;
    logic             pattern_en;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             txe_n;
    logic [7:0]       data;
    logic             wr_n;
    logic             siwu_n;
    logic             oe_n;
    logic [CNT_W-1:0] byte_count;
    logic [LVL_W-1:0] level;

    modport master (
        output enable, pattern_en, in_data, in_valid, txe_n,
        input  in_ready, data, wr_n, siwu_n, oe_n, byte_count, level
    );

    modport slave (
        input  enable, pattern_en, in_data, in_valid, txe_n,
        output in_ready, data, wr_n, siwu_n, oe_n, byte_count, level
    );
endinterface

// File: rtl/ft2232h_tx_stream.sv
// Transmit streamer for the FT2232H synchronous FIFO: buffers stream bytes (or an
// internal counting pattern), drives them one per clock while TXE# allows, and pulses
// SIWU# once after the link has gone idle following some traffic.
module ft2232h_tx_stream #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned IDLE_FLUSH = 64,
    parameter int unsigned CNT_W      = 32
) (
    input logic                comm_clk,
    input logic                rst_n,
    ft2232h_tx_stream_if.slave bus
);
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned LVL_W  = AW + 1;
    localparam int unsigned IDLE_W = 16;

    typedef enum logic [1:0] {StIdle, StSend, StFlush} state_e;

    logic [7:0]        mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              stage_vld_q, stage_vld_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        pat_q;
    logic [CNT_W-1:0]  byte_cnt_q;
    logic [IDLE_W-1:0] idle_cnt_q;
    logic              sent_q;
    logic              rdy_q;
    state_e            state_q;
    logic              siwu_n_q;

    logic fifo_empty, fifo_full, in_ready, push, accept;
    logic load_ok, load_fifo, load_pat, stage_load, idle_inc, flush_go;

    // Handshake and stage-load decisions for the coming edge.
    always_comb begin
        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == LVL_W'(DEPTH));
        // rdy_q keeps in_ready low until the first edge after reset release
        in_ready   = rdy_q & ~fifo_full & ~bus.pattern_en;
        push       = bus.in_valid & in_ready;
        accept     = stage_vld_q & bus.enable & ~bus.txe_n;
        // The stage refills on the accept edge itself; blocked during the flush cycle
        load_ok    = (~stage_vld_q | accept) & (state_q != StFlush);
        load_fifo  = load_ok & ~bus.pattern_en & ~fifo_empty;
        load_pat   = load_ok & bus.pattern_en;
        stage_load = load_fifo | load_pat;
        idle_inc   = ~stage_vld_q & fifo_empty & ~bus.pattern_en;
        // Fires on the edge where the idle count reaches IDLE_FLUSH
        flush_go   = idle_inc & sent_q & (state_q != StFlush) &
                     (idle_cnt_q == IDLE_W'(IDLE_FLUSH - 1));
    end

    // Next FIFO occupancy.
    always_comb begin
        level_d = level_q;
        if (push && !load_fifo) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push && load_fifo) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Next output stage contents; the staged byte is only replaced at a free/accept edge.
    always_comb begin
        stage_vld_d = stage_vld_q;
        data_d      = data_q;
        if (load_fifo) begin
            stage_vld_d = 1'b1;
            data_d      = mem_q[rd_ptr_q];
        end else if (load_pat) begin
            stage_vld_d = 1'b1;
            data_d      = pat_q;
        end else if (accept) begin
            stage_vld_d = 1'b0;
        end
    end

    // Buffer storage; contents need no reset since pointers and level define validity.
    always_ff @(posedge comm_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    // FIFO pointers, occupancy and output stage.
    always_ff @(posedge comm_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            stage_vld_q <= 1'b0;
            data_q      <= 8'h00;
            rdy_q       <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (load_fifo) rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q     <= level_d;
            stage_vld_q <= stage_vld_d;
            data_q      <= data_d;
            rdy_q       <= 1'b1;
        end
    end

    // Byte counter, pattern source, idle timer and sent-since-flush flag.
    always_ff @(posedge comm_clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q <= '0;
            pat_q      <= 8'h00;
            idle_cnt_q <= '0;
            sent_q     <= 1'b0;
        end else begin
            if (accept) byte_cnt_q <= byte_cnt_q + CNT_W'(1);
            if (load_pat) pat_q <= pat_q + 8'd1;
            if (accept) begin
                idle_cnt_q <= '0;
            end else if (idle_inc && idle_cnt_q != '1) begin
                idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
            end
            if (flush_go) begin
                sent_q <= 1'b0;
            end else if (accept) begin
                sent_q <= 1'b1;
            end
        end
    end

    // Link state machine with registered SIWU# strobe.
    always_ff @(posedge comm_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            siwu_n_q <= 1'b1;
        end else begin
            siwu_n_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (flush_go) begin
                        state_q  <= StFlush;
                        siwu_n_q <= 1'b0;
                    end else if (stage_load) begin
                        state_q <= StSend;
                    end
                end
                StSend: begin
                    if (flush_go) begin
                        state_q  <= StFlush;
                        siwu_n_q <= 1'b0;
                    end else if (!stage_vld_q && fifo_empty && !stage_load) begin
                        state_q <= StIdle;
                    end
                end
                StFlush: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.data       = data_q;
    // Gated combinationally so enable=0 or reset drops WR# without waiting for an edge
    assign bus.wr_n       = ~(stage_vld_q & bus.enable);
    assign bus.siwu_n     = siwu_n_q;
    assign bus.oe_n       = 1'b1;
    assign bus.byte_count = byte_cnt_q;
    assign bus.level      = level_q;
endmodule

// File: tb/tb_ft2232h_tx_stream.sv
// Self-checking bench for ft2232h_tx_stream: scoreboard of pushed bytes compared
// against bytes the device model accepts, plus directed hold/full/pattern/flush/reset cases.
module tb_ft2232h_tx_stream;
    localparam int unsigned DEPTH      = 16;
    localparam int unsigned IDLE_FLUSH = 64;
    localparam int unsigned CNT_W      = 32;

    logic comm_clk = 1'b0;
    logic rst_n    = 1'b1;

    always #5 comm_clk = ~comm_clk;

    ft2232h_tx_stream_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    ft2232h_tx_stream #(
        .DEPTH     (DEPTH),
        .IDLE_FLUSH(IDLE_FLUSH),
        .CNT_W     (CNT_W)
    ) dut (
        .comm_clk(comm_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    bit         pat_mode = 1'b0;
    logic [7:0] exp_pat  = 8'h00;
    int         acc_cnt  = 0;
    int         cyc      = 0;
    int         last_acc = 0;
    int         siwu_cnt = 0;
    int         siwu_gap = -1;
    int         idx;
    bit         took;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Scoreboard monitor: inputs change at posedge+1, so negedge values are what the
    // next posedge will act on.
    always @(negedge comm_clk) begin
        cyc++;
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_data);
            if (!bus.wr_n && !bus.txe_n) begin
                acc_cnt++;
                last_acc = cyc + 1; // accept lands on the following edge
                if (pat_mode) begin
                    check_eq("pattern_data", 32'(bus.data), 32'(exp_pat));
                    exp_pat = exp_pat + 8'd1;
                end else begin
                    check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) check_eq("sb_data", 32'(bus.data), 32'(exp_q.pop_front()));
                end
            end
            if (!bus.siwu_n) begin
                siwu_cnt++;
                siwu_gap = cyc - last_acc;
            end
        end
    end

    task automatic do_reset();
        bus.in_valid   = 1'b0;
        bus.in_data    = 8'h00;
        bus.txe_n      = 1'b1;
        bus.enable     = 1'b1;
        bus.pattern_en = 1'b0;
        pat_mode       = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_wr_n", 32'(bus.wr_n), 32'd1);
        check_eq("rst_level", 32'(bus.level), 32'd0);
        check_eq("rst_byte_count", bus.byte_count, 32'd0);
        check_eq("rst_data", 32'(bus.data), 32'd0);
        check_eq("rst_siwu_n", 32'(bus.siwu_n), 32'd1);
        check_eq("rst_oe_n", 32'(bus.oe_n), 32'd1);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
        exp_q.delete();
        acc_cnt = 0;
        exp_pat = 8'h00;
        repeat (2) @(posedge comm_clk);
        #3 rst_n = 1'b1;
        #1 check_eq("in_ready_before_edge", 32'(bus.in_ready), 32'd0);
        @(posedge comm_clk);
        #1 check_eq("in_ready_after_edge", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic push_byte(input logic [7:0] b);
        bit got = 1'b0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge comm_clk);
            got = bus.in_ready;
            @(posedge comm_clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check_eq("push_taken", 32'(got), 32'd1);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || !bus.wr_n) && n < 300) begin
            @(posedge comm_clk);
            #1;
            n++;
        end
        check_eq(tag, 32'(exp_q.size()), 32'd0);
        check_eq("drain_wr_n", 32'(bus.wr_n), 32'd1);
    endtask

    initial begin
        do_reset();

        // Three back-to-back bytes, then idle long enough for one flush.
        siwu_cnt  = 0;
        bus.txe_n = 1'b0;
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        check_eq("b2b_data1", 32'(bus.data), 32'h22);
        check_eq("b2b_wr1", 32'(bus.wr_n), 32'd0);
        @(posedge comm_clk); #1;
        check_eq("b2b_data2", 32'(bus.data), 32'h33);
        check_eq("b2b_wr2", 32'(bus.wr_n), 32'd0);
        @(posedge comm_clk); #1;
        check_eq("b2b_wr_idle", 32'(bus.wr_n), 32'd1);
        check_eq("b2b_count", bus.byte_count, 32'd3);
        repeat (200) @(posedge comm_clk);
        #1;
        check_eq("flush_pulses", 32'(siwu_cnt), 32'd1);
        check_eq("flush_delay", 32'(siwu_gap), 32'(IDLE_FLUSH));

        // TXE# back-pressure holding 0x22.
        bus.txe_n = 1'b1;
        push_byte(8'hA1);
        push_byte(8'h22);
        push_byte(8'hA3);
        repeat (2) @(posedge comm_clk);
        #1 check_eq("hold_first", 32'(bus.data), 32'hA1);
        bus.txe_n = 1'b0;
        @(posedge comm_clk);
        #1 bus.txe_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge comm_clk); #1;
            check_eq("hold_data", 32'(bus.data), 32'h22);
            check_eq("hold_wr_n", 32'(bus.wr_n), 32'd0);
            check_eq("hold_count", bus.byte_count, 32'd4);
        end
        bus.txe_n = 1'b0;
        wait_drain("hold_drain");
        check_eq("hold_total", bus.byte_count, 32'd6);

        // Fill: 20 offered, 16 in FIFO + 1 staged.
        bus.txe_n = 1'b1;
        idx = 0;
        for (int c = 0; c < 40; c++) begin
            bus.in_valid = (idx < 20);
            bus.in_data  = 8'h40 + 8'(idx);
            @(negedge comm_clk);
            took = bus.in_valid && bus.in_ready;
            @(posedge comm_clk); #1;
            if (took) idx++;
        end
        bus.in_valid = 1'b0;
        check_eq("full_taken", 32'(idx), 32'd17);
        check_eq("full_level", 32'(bus.level), 32'd16);
        check_eq("full_in_ready", 32'(bus.in_ready), 32'd0);
        bus.enable = 1'b0;
        bus.txe_n  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge comm_clk); #1;
            check_eq("disable_wr_n", 32'(bus.wr_n), 32'd1);
            check_eq("disable_count", bus.byte_count, 32'd6);
        end
        bus.enable = 1'b1;
        wait_drain("full_drain");
        check_eq("full_total", bus.byte_count, 32'd23);

        // Internal pattern for 300 accepts.
        do_reset();
        bus.pattern_en = 1'b1;
        pat_mode       = 1'b1;
        bus.txe_n      = 1'b0;
        #1 check_eq("pattern_in_ready", 32'(bus.in_ready), 32'd0);
        for (int n = 0; n < 1000 && acc_cnt < 300; n++) begin
            @(posedge comm_clk); #1;
        end
        bus.txe_n = 1'b1;
        check_eq("pattern_accepts", 32'(acc_cnt), 32'd300);
        check_eq("pattern_count", bus.byte_count, 32'd300);
        @(posedge comm_clk); #1;
        check_eq("pattern_next", 32'(bus.data), 32'h2C);
        check_eq("pattern_count_hold", bus.byte_count, 32'd300);

        // Reset mid-burst with five bytes buffered.
        bus.pattern_en = 1'b0;
        for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
        check_eq("midrst_level", 32'(bus.level), 32'd5);
        do_reset();

        // Nothing stale survives reset.
        bus.txe_n = 1'b0;
        push_byte(8'h5A);
        wait_drain("post_rst_drain");
        check_eq("post_rst_count", bus.byte_count, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
